koopa_sprite_renderer: RTL and testbench
========================================

# koopa_sprite_renderer

Read-side client of the Koopa sprite ROM. Converts the VGA raster position, the Koopa's screen position, its facing and its animation state into ROM addresses. Compensates for the ROM's one-cycle registered read and emits an aligned pixel colour plus an opaque/valid flag for the compositor. Contains the animation frame sequencer, which advances on the per-video-frame tick.

## Interface
- `SCREEN_W`, default 640: visible width; `hcount` is only meaningful below this.
- `SCREEN_H`, default 480: visible height.
- `IDLE_PERIOD`, default 16: frame_ticks per idle animation step.
- `WALK_PERIOD`, default 8: frame_ticks per walk animation step.

Ports:
- `clk` in 1: pixel clock, the single clock.
- `rst` in 1: synchronous, active-high reset.
- `hcount` in 10: current raster column.
- `vcount` in 10: current raster row.
- `sprite_x` in 10: screen column of the sprite's top-left corner.
- `sprite_y` in 10: screen row of the sprite's top-left corner.
- `anim_state` in 2: 0 idle, 1 walk, 2 shell, 3 reserved (treated as idle).
- `facing_left` in 1: 1 mirrors the sprite horizontally.
- `frame_tick` in 1: one-cycle pulse per video frame, issued during vblank.
- `rom_addr` out 13: address to the sprite ROM.
- `rom_rgb` in 6: ROM colour, valid one cycle after `rom_addr`.
- `pix_rgb` out 6: pixel colour; 0 when `pix_valid` is 0.
- `pix_valid` out 1: the pixel is inside the sprite box and not transparent.

## Operation
- Sprite sheet layout: 6 frames, each 23 wide × 30 tall = 690 words, row-major. Address = frame·690 + ly·23 + lx. The maximum address is 4139.
- Frame sets:
  - idle: frames 0,1, advancing every `IDLE_PERIOD` ticks.
  - walk: frames 2,3,4, advancing every `WALK_PERIOD` ticks and wrapping 4→2.
  - shell: frame 5, static.
- Shadow registers: `sprite_x`, `sprite_y`, `facing_left` and `anim_state` are captured into shadow registers only when `frame_tick`=1. All rendering uses the shadows, so no tearing occurs within a frame.
- Sequencer, evaluated on `frame_tick`:
  - If the sampled `anim_state` differs from the shadow state, set frame to the first frame of the new set and clear the tick counter. A state change takes priority over a period step on the same tick.
  - Otherwise increment the tick counter. When it reaches PERIOD−1, clear it and step the frame.
- Hit test:
  - dx = {1'b0,hcount} − {1'b0,sx}, computed at 11 bits; dy likewise.
  - Inside when dx < 23 and dy < 30, both compared unsigned. A negative difference wraps to a large value and therefore counts as outside.
  - A sprite at sx = 630 is clipped at the screen edge with no wrap onto column 0.
- Mirroring: lx = facing ? 22−dx : dx. ly = dy.
- Outside the box, `rom_addr` holds its previous value (no toggling) and the inside flag is 0.
- Transparency: `rom_rgb` == 6'b110011 gives `pix_valid`=0 and `pix_rgb`=0.
- anim_state 3 is handled exactly like idle.

## Timing
- Stage 1 (edge N+1): registers `rom_addr` and `inside_d1`, computed from hcount/vcount sampled at edge N.
- ROM (edge N+2): returns `rom_rgb`. `inside_d2` is registered at the same edge.
- Output: `pix_valid` = inside_d2 & (rom_rgb ≠ key). `pix_rgb` = pix_valid ? rom_rgb : 0. Both are combinational from `inside_d2` and `rom_rgb`. Total latency from raster position to pixel is 2 cycles; the upstream VGA timing must pre-advance hcount by 2.
- Values after reset:
  - `rom_addr`=0, inside_d1/d2=0, so `pix_valid`=0 and `pix_rgb`=0.
  - Shadow state = idle, frame 0, tick counter 0.
  - Shadow position = (0,0), facing = 0.
- A `frame_tick` coincident with `rst` is ignored; reset wins.
- Reset mid-line drops the two in-flight pixels. Output resumes 2 cycles after `rst` is deasserted.

## Structure
- `koopa_sprite_pkg` holds:
  - `KOOPA_W`=23, `KOOPA_H`=30, `KOOPA_FRAME_WORDS`=690, `KOOPA_NUM_FRAMES`=6.
  - `KOOPA_TRANSPARENT`=6'b110011.
  - `koopa_anim_e` enum {IDLE, WALK, SHELL}.
  - Frame base constants IDLE_BASE=0, WALK_BASE=2, SHELL_BASE=5.
- Sub-module `koopa_anim_seq` contains the shadow state, tick counter and frame register, and outputs a 3-bit frame index. The top level holds the hit test, address pipeline and output mask.
- Multiplies are by constants; implement them as shift-add, with no DSP requirement.

## Test plan
- Reset, sprite at (100,50) facing right, idle, one frame_tick. Drive hcount=100, vcount=50 → `rom_addr`=0 one cycle later; `pix_valid` follows the ROM model 2 cycles after input.
- facing_left=1 at the same position: hcount=100, vcount=51 → `rom_addr`=23+22=45. At hcount=122 → `rom_addr`=23.
- Walk state, 8 frame_ticks per step, 25 ticks in total → frames 2,3,4,2 observed. Check the address at local (0,0) = 1380, 2070, 2760, 1380.
- Switch to shell on the same cycle as a period-boundary tick → frame 5. Address at local (22,29) = 4139.
- ROM model returns 6'b110011 inside the box → `pix_valid`=0, `pix_rgb`=0. sprite_x=630, hcount=5 → outside, `pix_valid`=0.
- Assert `rst` while walking at frame 3 → next cycle `rom_addr`=0 and `pix_valid`=0. After release the sequencer is in idle, frame 0.

Source files
------------

// File: rtl/koopa_sprite_pkg.sv
// Shared constants, types and constant-multiply helpers for the Koopa sprite renderer.
// Sprite sheet: 6 frames of 23x30 words, row-major, frames stacked back to back.
package koopa_sprite_pkg;

  localparam int KOOPA_W           = 23;
  localparam int KOOPA_H           = 30;
  localparam int KOOPA_FRAME_WORDS = 690;
  localparam int KOOPA_NUM_FRAMES  = 6;

  localparam logic [5:0] KOOPA_TRANSPARENT = 6'b110011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    SHELL = 2'd2
  } koopa_anim_e;

  localparam logic [2:0] IDLE_BASE  = 3'd0;
  localparam logic [2:0] WALK_BASE  = 3'd2;
  localparam logic [2:0] WALK_LAST  = 3'd4;
  localparam logic [2:0] SHELL_BASE = 3'd5;

  // The reserved encoding collapses onto idle so it never forms a distinct state.
  function automatic koopa_anim_e decode_anim(input logic [1:0] raw);
    koopa_anim_e st;
    case (raw)
      2'd1:    st = WALK;
      2'd2:    st = SHELL;
      default: st = IDLE;
    endcase
    return st;
  endfunction

  function automatic logic [2:0] frame_base(input koopa_anim_e st);
    logic [2:0] base;
    case (st)
      WALK:    base = WALK_BASE;
      SHELL:   base = SHELL_BASE;
      default: base = IDLE_BASE;
    endcase
    return base;
  endfunction

  // frame * 690 = frame * (512 + 128 + 32 + 16 + 2)
  function automatic logic [12:0] mul_frame_words(input logic [2:0] frame);
    logic [12:0] f;
    f = {10'd0, frame};
    return (f << 9) + (f << 7) + (f << 5) + (f << 4) + (f << 1);
  endfunction

  // row * 23 = row * (16 + 4 + 2 + 1)
  function automatic logic [12:0] mul_width(input logic [4:0] row);
    logic [12:0] r;
    r = {8'd0, row};
    return (r << 4) + (r << 2) + (r << 1) + r;
  endfunction

endpackage

// File: rtl/koopa_anim_seq.sv
// Animation frame sequencer: shadows the requested animation state on each video
// frame tick and steps through the frame set of that state at its own period.
module koopa_anim_seq
  import koopa_sprite_pkg::*;
#(
  parameter int IDLE_PERIOD = 16,
  parameter int WALK_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [1:0] anim_state,
  output logic [2:0] frame
);

  localparam int MAX_PERIOD = (IDLE_PERIOD > WALK_PERIOD) ? IDLE_PERIOD : WALK_PERIOD;
  localparam int CNT_W      = $clog2(MAX_PERIOD + 1);

  localparam logic [CNT_W-1:0] IDLE_LAST_CNT = CNT_W'(IDLE_PERIOD - 1);
  localparam logic [CNT_W-1:0] WALK_LAST_CNT = CNT_W'(WALK_PERIOD - 1);

  koopa_anim_e      state_r;
  koopa_anim_e      req_state_s;
  logic [2:0]       frame_r;
  logic [2:0]       step_frame_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] last_cnt_s;

  // Next frame within the current set and the tick count that triggers it.
  always_comb begin
    req_state_s  = decode_anim(anim_state);
    step_frame_s = frame_r;
    last_cnt_s   = IDLE_LAST_CNT;
    case (state_r)
      IDLE: begin
        last_cnt_s   = IDLE_LAST_CNT;
        step_frame_s = (frame_r == IDLE_BASE) ? (IDLE_BASE + 3'd1) : IDLE_BASE;
      end
      WALK: begin
        last_cnt_s   = WALK_LAST_CNT;
        step_frame_s = (frame_r == WALK_LAST) ? WALK_BASE : (frame_r + 3'd1);
      end
      SHELL: begin
        last_cnt_s   = IDLE_LAST_CNT;
        step_frame_s = SHELL_BASE;
      end
      default: begin
        last_cnt_s   = IDLE_LAST_CNT;
        step_frame_s = IDLE_BASE;
      end
    endcase
  end

  // State change outranks a period step landing on the same tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      frame_r <= IDLE_BASE;
      cnt_r   <= '0;
    end else if (frame_tick) begin
      if (req_state_s != state_r) begin
        state_r <= req_state_s;
        frame_r <= frame_base(req_state_s);
        cnt_r   <= '0;
      end else if (cnt_r == last_cnt_s) begin
        frame_r <= step_frame_s;
        cnt_r   <= '0;
      end else begin
        cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign frame = frame_r;

endmodule

// File: rtl/koopa_sprite_renderer.sv
// Koopa sprite ROM read client: hit test, mirrored address generation and a
// two-cycle aligned pixel output with colour-key transparency.
module koopa_sprite_renderer
  import koopa_sprite_pkg::*;
#(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int IDLE_PERIOD = 16,
  parameter int WALK_PERIOD = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic [9:0]  sprite_x,
  input  logic [9:0]  sprite_y,
  input  logic [1:0]  anim_state,
  input  logic        facing_left,
  input  logic        frame_tick,
  output logic [12:0] rom_addr,
  input  logic [5:0]  rom_rgb,
  output logic [5:0]  pix_rgb,
  output logic        pix_valid
);

  localparam logic [10:0] SCREEN_W_L = 11'(SCREEN_W);
  localparam logic [10:0] SCREEN_H_L = 11'(SCREEN_H);
  localparam logic [10:0] KOOPA_W_L  = 11'(KOOPA_W);
  localparam logic [10:0] KOOPA_H_L  = 11'(KOOPA_H);
  localparam logic [4:0]  LAST_COL   = 5'(KOOPA_W - 1);

  logic [9:0]  sx_r;
  logic [9:0]  sy_r;
  logic        facing_r;
  logic [2:0]  frame_s;
  logic [10:0] dx_s;
  logic [10:0] dy_s;
  logic        inside_s;
  logic [4:0]  lx_s;
  logic [4:0]  ly_s;
  logic [12:0] addr_s;
  logic [12:0] rom_addr_r;
  logic        inside_d1_r;
  logic        inside_d2_r;

  koopa_anim_seq #(
    .IDLE_PERIOD (IDLE_PERIOD),
    .WALK_PERIOD (WALK_PERIOD)
  ) u_anim_seq (
    .clk        (clk),
    .rst        (rst),
    .frame_tick (frame_tick),
    .anim_state (anim_state),
    .frame      (frame_s)
  );

  // Position and facing are latched once per video frame so a frame never tears.
  always_ff @(posedge clk) begin
    if (rst) begin
      sx_r     <= 10'd0;
      sy_r     <= 10'd0;
      facing_r <= 1'b0;
    end else if (frame_tick) begin
      sx_r     <= sprite_x;
      sy_r     <= sprite_y;
      facing_r <= facing_left;
    end
  end

  // Negative offsets wrap to large unsigned values and fall outside the box.
  always_comb begin
    dx_s     = {1'b0, hcount} - {1'b0, sx_r};
    dy_s     = {1'b0, vcount} - {1'b0, sy_r};
    inside_s = (dx_s < KOOPA_W_L) && (dy_s < KOOPA_H_L) &&
               ({1'b0, hcount} < SCREEN_W_L) && ({1'b0, vcount} < SCREEN_H_L);
    lx_s     = facing_r ? (LAST_COL - dx_s[4:0]) : dx_s[4:0];
    ly_s     = dy_s[4:0];
    addr_s   = mul_frame_words(frame_s) + mul_width(ly_s) + {8'd0, lx_s};
  end

  // Address holds outside the box; the inside flag tracks the ROM read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_r  <= 13'd0;
      inside_d1_r <= 1'b0;
      inside_d2_r <= 1'b0;
    end else begin
      if (inside_s) begin
        rom_addr_r <= addr_s;
      end
      inside_d1_r <= inside_s;
      inside_d2_r <= inside_d1_r;
    end
  end

  assign rom_addr  = rom_addr_r;
  assign pix_valid = inside_d2_r & (rom_rgb != KOOPA_TRANSPARENT);
  assign pix_rgb   = pix_valid ? rom_rgb : 6'd0;

endmodule

// File: tb/tb_koopa_sprite_renderer.sv
// Directed self-checking bench for koopa_sprite_renderer with a registered ROM model.
module tb_koopa_sprite_renderer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic [9:0]  sprite_x;
  logic [9:0]  sprite_y;
  logic [1:0]  anim_state;
  logic        facing_left;
  logic        frame_tick;
  logic [12:0] rom_addr;
  logic [5:0]  rom_rgb;
  logic [5:0]  pix_rgb;
  logic        pix_valid;

  logic key_mode = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  koopa_sprite_renderer dut (
    .clk         (clk),
    .rst         (rst),
    .hcount      (hcount),
    .vcount      (vcount),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .anim_state  (anim_state),
    .facing_left (facing_left),
    .frame_tick  (frame_tick),
    .rom_addr    (rom_addr),
    .rom_rgb     (rom_rgb),
    .pix_rgb     (pix_rgb),
    .pix_valid   (pix_valid)
  );

  // ROM content: never the colour key unless key_mode forces it.
  function automatic logic [5:0] rom_f(input logic [12:0] a);
    logic [5:0] v;
    v = a[5:0] ^ 6'h15;
    if (v == 6'b110011) v = 6'h2a;
    return v;
  endfunction

  always @(posedge clk) rom_rgb <= key_mode ? 6'b110011 : rom_f(rom_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; hcount = 10'd0; vcount = 10'd0; sprite_x = 10'd0; sprite_y = 10'd0;
    anim_state = 2'd0; facing_left = 1'b0; frame_tick = 1'b0;
    tick(); tick(); tick();
    checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", rom_addr); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", pix_valid); end
    checks++; if (pix_rgb !== 6'd0) begin errors++; $display("FAIL reset_rgb got %0h want 0", pix_rgb); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_idle_right();
    sprite_x = 10'd100; sprite_y = 10'd50; facing_left = 1'b0; anim_state = 2'd0;
    pulse_tick();
    hcount = 10'd100; vcount = 10'd50;
    tick();
    checks++; if (rom_addr !== 13'd0) begin errors++; $display("FAIL idle_addr got %0d want 0", rom_addr); end
    tick();
    checks++; if (pix_valid !== 1'b1) begin errors++; $display("FAIL idle_valid got %0b want 1", pix_valid); end
    checks++; if (pix_rgb !== rom_f(13'd0)) begin errors++; $display("FAIL idle_rgb got %0h want %0h", pix_rgb, rom_f(13'd0)); end
    hcount = 10'd101; tick();
    checks++; if (rom_addr !== 13'd1) begin errors++; $display("FAIL idle_addr1 got %0d want 1", rom_addr); end
    hcount = 10'd99; tick(); tick();
    checks++; if (rom_addr !== 13'd1) begin errors++; $display("FAIL hold_addr got %0d want 1", rom_addr); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL left_outside got %0b want 0", pix_valid); end
  endtask

  task automatic test_mirror();
    facing_left = 1'b1;
    pulse_tick();
    hcount = 10'd100; vcount = 10'd51; tick();
    checks++; if (rom_addr !== 13'd45) begin errors++; $display("FAIL mirror_addr45 got %0d want 45", rom_addr); end
    hcount = 10'd122; tick();
    checks++; if (rom_addr !== 13'd23) begin errors++; $display("FAIL mirror_addr23 got %0d want 23", rom_addr); end
    tick();
    checks++; if (pix_valid !== 1'b1 || pix_rgb !== rom_f(13'd23)) begin errors++; $display("FAIL mirror_pix got %0b/%0h want 1/%0h", pix_valid, pix_rgb, rom_f(13'd23)); end
    hcount = 10'd123; tick(); tick();
    checks++; if (rom_addr !== 13'd23 || pix_valid !== 1'b0) begin errors++; $display("FAIL right_outside got %0d/%0b want 23/0", rom_addr, pix_valid); end
  endtask

  task automatic test_walk();
    logic [12:0] exp_addr;
    facing_left = 1'b0; anim_state = 2'd1; vcount = 10'd50;
    for (int i = 1; i <= 25; i++) begin
      pulse_tick();
      hcount = 10'd100; tick();
      if (i < 9) exp_addr = 13'd1380;
      else if (i < 17) exp_addr = 13'd2070;
      else if (i < 25) exp_addr = 13'd2760;
      else exp_addr = 13'd1380;
      checks++; if (rom_addr !== exp_addr) begin errors++; $display("FAIL walk_tick%0d got %0d want %0d", i, rom_addr, exp_addr); end
      hcount = 10'd0;
    end
  endtask

  task automatic test_shell_priority();
    for (int i = 0; i < 7; i++) pulse_tick();
    hcount = 10'd100; vcount = 10'd50; tick();
    checks++; if (rom_addr !== 13'd1380) begin errors++; $display("FAIL walk_pre_boundary got %0d want 1380", rom_addr); end
    anim_state = 2'd2;
    pulse_tick();
    hcount = 10'd122; vcount = 10'd79; tick();
    checks++; if (rom_addr !== 13'd4139) begin errors++; $display("FAIL shell_addr got %0d want 4139", rom_addr); end
    tick();
    checks++; if (pix_valid !== 1'b1 || pix_rgb !== rom_f(13'd4139)) begin errors++; $display("FAIL shell_pix got %0b/%0h want 1/%0h", pix_valid, pix_rgb, rom_f(13'd4139)); end
  endtask

  task automatic test_key_and_clip();
    key_mode = 1'b1;
    hcount = 10'd105; vcount = 10'd55; tick(); tick();
    checks++; if (pix_valid !== 1'b0 || pix_rgb !== 6'd0) begin errors++; $display("FAIL key_transparent got %0b/%0h want 0/0", pix_valid, pix_rgb); end
    key_mode = 1'b0;
    sprite_x = 10'd630;
    pulse_tick();
    hcount = 10'd5; tick(); tick();
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL clip_nowrap got %0b want 0", pix_valid); end
    hcount = 10'd635; tick(); tick();
    // local (5,5) of shell: 3450 + 115 + 5
    checks++; if (rom_addr !== 13'd3570 || pix_valid !== 1'b1) begin errors++; $display("FAIL clip_visible got %0d/%0b want 3570/1", rom_addr, pix_valid); end
  endtask

  task automatic test_reset_midwalk();
    sprite_x = 10'd100; anim_state = 2'd1;
    pulse_tick();
    for (int i = 0; i < 8; i++) pulse_tick();
    hcount = 10'd100; vcount = 10'd50; tick();
    checks++; if (rom_addr !== 13'd2070) begin errors++; $display("FAIL prereset_frame3 got %0d want 2070", rom_addr); end
    rst = 1'b1; frame_tick = 1'b1; anim_state = 2'd2;
    tick();
    checks++; if (rom_addr !== 13'd0 || pix_valid !== 1'b0) begin errors++; $display("FAIL reset_midline got %0d/%0b want 0/0", rom_addr, pix_valid); end
    rst = 1'b0; frame_tick = 1'b0; anim_state = 2'd0;
    hcount = 10'd1; vcount = 10'd1; tick();
    checks++; if (rom_addr !== 13'd24) begin errors++; $display("FAIL postreset_idle0 got %0d want 24", rom_addr); end
    tick();
    checks++; if (pix_valid !== 1'b1 || pix_rgb !== rom_f(13'd24)) begin errors++; $display("FAIL postreset_pix got %0b/%0h want 1/%0h", pix_valid, pix_rgb, rom_f(13'd24)); end
  endtask

  initial begin
    test_reset();
    test_idle_right();
    test_mirror();
    test_walk();
    test_shell_priority();
    test_key_and_clip();
    test_reset_midwalk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
